mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 169 ++++++++++++++++
 tb/tb_mem_access.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// MEM stage data-memory access unit.
// Non-memory ops pass straight through to the write-back outputs. Aligned
// loads/stores issue a single request on the data bus, stall the pipeline
// until the bus acknowledges, then present the result for one DONE cycle.
// Misaligned ops raise a one-cycle misalign pulse and never touch the bus.
// While the bus access is pending the rd write enable is held low; the
// rd/csr address and data fields are always forwarded unchanged.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  mem_rd_addr,
  input  logic        mem_rd_w_ena,
  input  logic [63:0] mem_wdata,
  input  logic [63:0] mem_mem_addr,
  input  logic [63:0] mem_mem_data,
  input  logic [3:0]  mem_inst_type,
  input  logic [4:0]  mem_exe_type,
  input  logic [11:0] mem_csr_w_addr,
  input  logic        mem_csr_w_ena,
  input  logic [63:0] mem_csr_wdata,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [63:0] dbus_addr,
  output logic [63:0] dbus_wdata,
  output logic [7:0]  dbus_wstrb,
  input  logic        dbus_ack,
  input  logic [63:0] dbus_rdata,
  output logic [5:0]  wb_rd_addr,
  output logic        wb_rd_w_ena,
  output logic [63:0] wb_wdata,
  output logic [11:0] wb_csr_w_addr,
  output logic        wb_csr_w_ena,
  output logic [63:0] wb_csr_wdata,
  output logic        stall_req,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state;
  logic [63:0] ld_data;

  logic        is_load, is_store, is_mem;
  logic [1:0]  size;        // 0=byte 1=half 2=word 3=double
  logic        is_unsigned;
  logic [2:0]  a;
  logic        misaligned;
  logic        issue, bus_active;
  logic [63:0] st_data;
  logic [7:0]  st_strb;
  logic [63:0] rd_shift;
  logic [63:0] ld_val;
  logic        unused_ok;

  assign is_load     = (mem_inst_type == 4'h3);
  assign is_store    = (mem_inst_type == 4'h4);
  assign is_mem      = is_load | is_store;
  assign size        = mem_exe_type[1:0];
  assign is_unsigned = mem_exe_type[2];
  assign a           = mem_mem_addr[2:0];
  assign unused_ok   = ^mem_exe_type[4:3];

  assign issue      = (state == IDLE) && is_mem && !misaligned;
  assign bus_active = issue || (state == WAIT);
  assign rd_shift   = dbus_rdata >> {a, 3'b000};

  // Alignment check by access size
  always_comb begin
    misaligned = 1'b0;
    case (size)
      2'd1:    misaligned = a[0];
      2'd2:    misaligned = |a[1:0];
      2'd3:    misaligned = |a;
      default: misaligned = 1'b0;
    endcase
    misaligned = misaligned & is_mem;
  end

  // Store lane replication and byte strobes
  always_comb begin
    st_data = '0;
    st_strb = '0;
    case (size)
      2'd0: begin st_data = {8{mem_mem_data[7:0]}};  st_strb = 8'h01 << a; end
      2'd1: begin st_data = {4{mem_mem_data[15:0]}}; st_strb = 8'h03 << a; end
      2'd2: begin st_data = {2{mem_mem_data[31:0]}}; st_strb = 8'h0F << a; end
      default: begin st_data = mem_mem_data;         st_strb = 8'hFF;      end
    endcase
  end

  // Load lane extraction with sign/zero extension
  always_comb begin
    ld_val = '0;
    case (size)
      2'd0: ld_val = is_unsigned ? {56'b0, rd_shift[7:0]}
                                 : {{56{rd_shift[7]}}, rd_shift[7:0]};
      2'd1: ld_val = is_unsigned ? {48'b0, rd_shift[15:0]}
                                 : {{48{rd_shift[15]}}, rd_shift[15:0]};
      2'd2: ld_val = is_unsigned ? {32'b0, rd_shift[31:0]}
                                 : {{32{rd_shift[31]}}, rd_shift[31:0]};
      default: ld_val = rd_shift;
    endcase
  end

  // Access FSM and load-result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ld_data <= '0;
    end else begin
      case (state)
        IDLE: if (issue) begin
          if (dbus_ack) begin
            state <= DONE;
            if (is_load) ld_data <= ld_val;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: if (dbus_ack) begin
          state <= DONE;
          if (is_load) ld_data <= ld_val;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Bus, write-back and control outputs; rst forces all of them low at once
  always_comb begin
    dbus_req      = 1'b0;
    dbus_we       = 1'b0;
    dbus_addr     = '0;
    dbus_wdata    = '0;
    dbus_wstrb    = '0;
    wb_rd_addr    = '0;
    wb_rd_w_ena   = 1'b0;
    wb_wdata      = '0;
    wb_csr_w_addr = '0;
    wb_csr_w_ena  = 1'b0;
    wb_csr_wdata  = '0;
    stall_req     = 1'b0;
    misalign      = 1'b0;
    if (!rst) begin
      wb_rd_addr    = mem_rd_addr;
      wb_wdata      = mem_wdata;
      wb_csr_w_addr = mem_csr_w_addr;
      wb_csr_w_ena  = mem_csr_w_ena;
      wb_csr_wdata  = mem_csr_wdata;
      if (bus_active) begin
        dbus_req   = 1'b1;
        dbus_we    = is_store;
        dbus_addr  = {mem_mem_addr[63:3], 3'b000};
        dbus_wdata = is_store ? st_data : '0;
        dbus_wstrb = is_store ? st_strb : '0;
        stall_req  = 1'b1;
      end else if (state == DONE) begin
        wb_wdata    = is_load ? ld_data : mem_wdata;
        wb_rd_w_ena = mem_rd_w_ena && !is_store && (mem_rd_addr != 6'd0);
      end else begin
        misalign    = misaligned;
        wb_rd_w_ena = mem_rd_w_ena && !is_store && !misaligned
                      && (mem_rd_addr != 6'd0);
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: transaction-level reference model with
// a per-cycle compare process, directed literal cases and randomized ops.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  mem_rd_addr;
  logic        mem_rd_w_ena;
  logic [63:0] mem_wdata, mem_mem_addr, mem_mem_data;
  logic [3:0]  mem_inst_type;
  logic [4:0]  mem_exe_type;
  logic [11:0] mem_csr_w_addr;
  logic        mem_csr_w_ena;
  logic [63:0] mem_csr_wdata;
  logic        dbus_req, dbus_we, dbus_ack;
  logic [63:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [7:0]  dbus_wstrb;
  logic [5:0]  wb_rd_addr;
  logic        wb_rd_w_ena, wb_csr_w_ena, stall_req, misalign;
  logic [63:0] wb_wdata, wb_csr_wdata;
  logic [11:0] wb_csr_w_addr;

  mem_access dut (
    .clk(clk), .rst(rst),
    .mem_rd_addr(mem_rd_addr), .mem_rd_w_ena(mem_rd_w_ena),
    .mem_wdata(mem_wdata), .mem_mem_addr(mem_mem_addr),
    .mem_mem_data(mem_mem_data), .mem_inst_type(mem_inst_type),
    .mem_exe_type(mem_exe_type), .mem_csr_w_addr(mem_csr_w_addr),
    .mem_csr_w_ena(mem_csr_w_ena), .mem_csr_wdata(mem_csr_wdata),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb), .dbus_ack(dbus_ack),
    .dbus_rdata(dbus_rdata), .wb_rd_addr(wb_rd_addr),
    .wb_rd_w_ena(wb_rd_w_ena), .wb_wdata(wb_wdata),
    .wb_csr_w_addr(wb_csr_w_addr), .wb_csr_w_ena(wb_csr_w_ena),
    .wb_csr_wdata(wb_csr_wdata), .stall_req(stall_req), .misalign(misalign)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // expected outputs for the current cycle
  logic        chk_en = 1'b0;
  logic        exp_req, exp_we, exp_stall, exp_mis, exp_wen, exp_wb_valid;
  logic [63:0] exp_addr, exp_wdata, exp_wb;
  logic [7:0]  exp_wstrb;

  // values captured by run_op for the literal checks
  int          cap_stall_cnt;
  logic        cap_req, cap_we, cap_mis, cap_stall0, cap_done_wen, cap_done_stall;
  logic [63:0] cap_addr, cap_wdata, cap_done_wdata;
  logic [7:0]  cap_wstrb;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("dbus_req", {63'b0, dbus_req}, {63'b0, exp_req});
      cmp("stall_req", {63'b0, stall_req}, {63'b0, exp_stall});
      cmp("misalign", {63'b0, misalign}, {63'b0, exp_mis});
      cmp("wb_rd_addr", {58'b0, wb_rd_addr}, {58'b0, mem_rd_addr});
      cmp("wb_csr_w_addr", {52'b0, wb_csr_w_addr}, {52'b0, mem_csr_w_addr});
      cmp("wb_csr_w_ena", {63'b0, wb_csr_w_ena}, {63'b0, mem_csr_w_ena});
      cmp("wb_csr_wdata", wb_csr_wdata, mem_csr_wdata);
      if (exp_req) begin
        cmp("dbus_we", {63'b0, dbus_we}, {63'b0, exp_we});
        cmp("dbus_addr", dbus_addr, exp_addr);
        cmp("dbus_wstrb", {56'b0, dbus_wstrb}, {56'b0, exp_wstrb});
        if (exp_we) cmp("dbus_wdata", dbus_wdata, exp_wdata);
      end
      if (exp_wb_valid) begin
        cmp("wb_rd_w_ena", {63'b0, wb_rd_w_ena}, {63'b0, exp_wen});
        cmp("wb_wdata", wb_wdata, exp_wb);
      end
    end
  end

  // Drive one instruction through MEM and keep the expectations current.
  task automatic run_op(input logic [3:0] it, input logic [4:0] et,
                        input logic [63:0] addr, input logic [63:0] sdata,
                        input logic [63:0] alu, input logic [63:0] rdata,
                        input logic [5:0] rd, input logic rd_en,
                        input int unsigned dly);
    logic        is_ld, is_st, mis;
    int unsigned n, off;
    logic [63:0] mask, ldv, rep;
    logic [15:0] strb16;

    @(posedge clk); #1;
    mem_inst_type  = it;      mem_exe_type  = et;
    mem_mem_addr   = addr;    mem_mem_data  = sdata;
    mem_wdata      = alu;     dbus_rdata    = rdata;
    mem_rd_addr    = rd;      mem_rd_w_ena  = rd_en;
    mem_csr_w_addr = 12'($urandom);
    mem_csr_w_ena  = 1'($urandom);
    mem_csr_wdata  = {$urandom, $urandom};

    is_ld = (it == 4'h3);
    is_st = (it == 4'h4);
    n     = 1 << et[1:0];
    off   = 32'(addr[2:0]);
    mis   = (is_ld || is_st) && ((off % n) != 0);
    mask  = (n == 8) ? {64{1'b1}} : ((64'd1 << (8 * n)) - 64'd1);

    ldv = (rdata >> (8 * off)) & mask;
    if (!et[2] && n < 8 && ldv[8 * n - 1]) ldv = ldv | ~mask;
    rep = '0;
    for (int unsigned i = 0; i < 8 / n; i++)
      rep = rep | ((sdata & mask) << (8 * n * i));
    strb16 = ((16'd1 << n) - 16'd1) << off;

    cap_stall_cnt = 0;
    if (!(is_ld || is_st) || mis) begin
      dbus_ack     = 1'($urandom);
      exp_req      = 1'b0; exp_stall = 1'b0; exp_mis = mis;
      exp_we       = 1'b0; exp_addr = '0; exp_wdata = '0; exp_wstrb = '0;
      exp_wb_valid = 1'b1;
      exp_wen      = rd_en && (rd != 0) && !mis && !is_st;
      exp_wb       = alu;
      chk_en       = 1'b1;
      @(negedge clk); #1;
      cap_req = dbus_req; cap_stall0 = stall_req; cap_mis = misalign;
      cap_done_wdata = wb_wdata; cap_done_wen = wb_rd_w_ena;
      cap_done_stall = stall_req;
    end else begin
      for (int unsigned k = 0; k <= dly; k++) begin
        if (k > 0) begin @(posedge clk); #1; end
        dbus_ack     = (k == dly);
        exp_req      = 1'b1; exp_stall = 1'b1; exp_mis = 1'b0;
        exp_we       = is_st;
        exp_addr     = addr & ~64'h7;
        exp_wdata    = rep;
        exp_wstrb    = is_st ? strb16[7:0] : 8'h00;
        exp_wb_valid = 1'b0;
        chk_en       = 1'b1;
        @(negedge clk); #1;
        if (stall_req) cap_stall_cnt++;
        if (k == 0) begin
          cap_req = dbus_req; cap_we = dbus_we; cap_addr = dbus_addr;
          cap_wdata = dbus_wdata; cap_wstrb = dbus_wstrb;
          cap_mis = misalign; cap_stall0 = stall_req;
        end
      end
      @(posedge clk); #1;
      dbus_ack     = 1'($urandom);
      exp_req      = 1'b0; exp_stall = 1'b0; exp_mis = 1'b0;
      exp_wb_valid = 1'b1;
      exp_wen      = is_ld && rd_en && (rd != 0);
      exp_wb       = is_ld ? ldv : alu;
      @(negedge clk); #1;
      cap_done_wdata = wb_wdata; cap_done_wen = wb_rd_w_ena;
      cap_done_stall = stall_req;
    end
  endtask

  initial begin
    logic [3:0]  it;
    logic [4:0]  et;
    logic [63:0] addr;
    int unsigned n, v;

    // reset with an aligned load presented: every output must read zero
    rst = 1'b1; dbus_ack = 1'b1; dbus_rdata = 64'hDEAD_BEEF_0000_1111;
    mem_inst_type = 4'h3; mem_exe_type = 5'd3; mem_mem_addr = 64'h1000;
    mem_mem_data = 64'h55; mem_wdata = 64'h99; mem_rd_addr = 6'd5;
    mem_rd_w_ena = 1'b1; mem_csr_w_addr = 12'h305; mem_csr_w_ena = 1'b1;
    mem_csr_wdata = 64'h1234;
    #3;
    cmp("rst dbus_req", {63'b0, dbus_req}, 64'd0);
    cmp("rst stall_req", {63'b0, stall_req}, 64'd0);
    cmp("rst wb_wdata", wb_wdata, 64'd0);
    cmp("rst wb_rd_w_ena", {63'b0, wb_rd_w_ena}, 64'd0);
    cmp("rst wb_csr_wdata", wb_csr_wdata, 64'd0);
    cmp("rst wb_csr_w_ena", {63'b0, wb_csr_w_ena}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_inst_type = 4'h0;
    rst = 1'b0;

    // ADD to rd 3, then to rd 0
    run_op(4'h1, 5'd0, 64'h0, 64'h0, 64'h5, 64'h0, 6'd3, 1'b1, 0);
    cmp("add wb_wdata", cap_done_wdata, 64'h5);
    cmp("add wb_rd_w_ena", {63'b0, cap_done_wen}, 64'd1);
    cmp("add stall_req", {63'b0, cap_stall0}, 64'd0);
    run_op(4'h1, 5'd0, 64'h0, 64'h0, 64'h5, 64'h0, 6'd0, 1'b1, 0);
    cmp("add rd0 wb_rd_w_ena", {63'b0, cap_done_wen}, 64'd0);

    // LD with ack two cycles after issue
    run_op(4'h3, 5'd3, 64'h1000, 64'h0, 64'h0, 64'h1122334455667788, 6'd7, 1'b1, 2);
    cmp("ld stall cycles", 64'(cap_stall_cnt), 64'd3);
    cmp("ld dbus_addr", cap_addr, 64'h1000);
    cmp("ld done wb_wdata", cap_done_wdata, 64'h1122334455667788);
    cmp("ld done wb_rd_w_ena", {63'b0, cap_done_wen}, 64'd1);
    cmp("ld done stall_req", {63'b0, cap_done_stall}, 64'd0);

    // LB / LBU at the top byte
    run_op(4'h3, 5'd0, 64'h1007, 64'h0, 64'h0, 64'h8011223344556677, 6'd8, 1'b1, 1);
    cmp("lb wb_wdata", cap_done_wdata, 64'hFFFFFFFFFFFFFF80);
    run_op(4'h3, 5'd4, 64'h1007, 64'h0, 64'h0, 64'h8011223344556677, 6'd8, 1'b1, 0);
    cmp("lbu wb_wdata", cap_done_wdata, 64'h80);

    // SH at offset 2
    run_op(4'h4, 5'd9, 64'h1002, 64'hABCD, 64'h0, 64'h0, 6'd9, 1'b1, 1);
    cmp("sh dbus_addr", cap_addr, 64'h1000);
    cmp("sh dbus_wstrb", {56'b0, cap_wstrb}, 64'h0C);
    cmp("sh dbus_wdata", cap_wdata, 64'hABCDABCDABCDABCD);
    cmp("sh dbus_we", {63'b0, cap_we}, 64'd1);
    cmp("sh wb_rd_w_ena", {63'b0, cap_done_wen}, 64'd0);

    // misaligned LW, then a plain op: pulse lasts one cycle
    run_op(4'h3, 5'd2, 64'h1002, 64'h0, 64'h0, 64'h0, 6'd4, 1'b1, 0);
    cmp("lw mis misalign", {63'b0, cap_mis}, 64'd1);
    cmp("lw mis dbus_req", {63'b0, cap_req}, 64'd0);
    cmp("lw mis stall_req", {63'b0, cap_stall0}, 64'd0);
    cmp("lw mis wb_rd_w_ena", {63'b0, cap_done_wen}, 64'd0);
    run_op(4'h1, 5'd0, 64'h0, 64'h0, 64'h6, 64'h0, 6'd4, 1'b1, 0);
    cmp("after mis misalign", {63'b0, cap_mis}, 64'd0);

    // reset mid-WAIT, released between clock edges, then a late ack
    @(posedge clk); #1;
    chk_en = 1'b0;
    mem_inst_type = 4'h3; mem_exe_type = 5'd3; mem_mem_addr = 64'h2000;
    mem_rd_addr = 6'd4; mem_rd_w_ena = 1'b1; dbus_ack = 1'b0;
    @(posedge clk); #2;
    cmp("wait stall_req", {63'b0, stall_req}, 64'd1);
    rst = 1'b1; #1;
    cmp("midrst dbus_req", {63'b0, dbus_req}, 64'd0);
    cmp("midrst stall_req", {63'b0, stall_req}, 64'd0);
    cmp("midrst wb_rd_addr", {58'b0, wb_rd_addr}, 64'd0);
    mem_inst_type = 4'h1; mem_wdata = 64'h77; dbus_ack = 1'b1;
    #1 rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      cmp("late ack dbus_req", {63'b0, dbus_req}, 64'd0);
      cmp("late ack stall_req", {63'b0, stall_req}, 64'd0);
      cmp("late ack wb_wdata", wb_wdata, 64'h77);
    end

    // randomized ops
    for (int i = 0; i < 300; i++) begin
      v = $urandom_range(0, 9);
      if (v < 4) begin
        it = 4'h3; et = 5'($urandom_range(0, 6));
      end else if (v < 7) begin
        it = 4'h4; et = 5'($urandom_range(8, 11));
      end else begin
        v = $urandom_range(0, 13);
        it = (v < 3) ? 4'(v) : 4'(v + 2);
        et = 5'($urandom_range(0, 31));
      end
      addr = {$urandom, $urandom};
      n = 1 << et[1:0];
      if ($urandom_range(0, 3) != 0) addr = addr & ~64'(n - 1);
      run_op(it, et, addr, {$urandom, $urandom}, {$urandom, $urandom},
             {$urandom, $urandom},
             ($urandom_range(0, 4) == 0) ? 6'd0 : 6'($urandom),
             1'($urandom), $urandom_range(0, 3));
    end

    chk_en = 1'b0;
    @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
